// File: rtl/reloj_nios2_qsys_0_div_cell.sv
// rtl/reloj_nios2_qsys_0_div_cell.sv - iterative radix-2 restoring 32-bit divider cell
//
// Purpose: serves div/divu for the reloj Nios II A stage. Produces the quotient
// and remainder of two 32-bit operands, one quotient bit per cycle, under a
// start/done handshake. Latency is 35 cycles from start to done, or 2 cycles
// when the divisor is zero.
//
// Configuration macro: RELOJ_DIV_SIGNED_EN
//   defined   : A_div_signed selects two's complement division (div), with
//               magnitude conversion in PREP and sign correction in FIX.
//   undefined : every operation is unsigned; FIX only registers the results.
//
// Ports:
//   clk            in   clock, rising edge
//   reset_n        in   synchronous active-low reset
//   A_div_start    in   request pulse, accepted only in IDLE or DONE
//   A_div_src1     in   dividend, sampled with an accepted start
//   A_div_src2     in   divisor, sampled with an accepted start
//   A_div_signed   in   1 = div, 0 = divu, sampled with an accepted start
//   A_div_busy     out  high while in PREP, ITER or FIX
//   A_div_done     out  one-cycle pulse, results valid in that cycle
//   A_div_quot     out  quotient, held until the next done
//   A_div_rem      out  remainder, held until the next done
//   A_div_by_zero  out  set when the last presented result was a divide by zero

module reloj_nios2_qsys_0_div_cell #(
  parameter int DIV_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 A_div_start,
  input  logic [DIV_WIDTH-1:0] A_div_src1,
  input  logic [DIV_WIDTH-1:0] A_div_src2,
  input  logic                 A_div_signed,
  output logic                 A_div_busy,
  output logic                 A_div_done,
  output logic [DIV_WIDTH-1:0] A_div_quot,
  output logic [DIV_WIDTH-1:0] A_div_rem,
  output logic                 A_div_by_zero
);

`ifdef RELOJ_DIV_SIGNED_EN
  localparam logic SIGNED_EN = 1'b1;
`else
  localparam logic SIGNED_EN = 1'b0;
`endif

  localparam int CNT_W = $clog2(DIV_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t               state;
  logic [DIV_WIDTH-1:0] op1;      // dividend as presented, kept for the divide-by-zero remainder
  logic [DIV_WIDTH-1:0] op2;
  logic                 sgn;
  logic [DIV_WIDTH-1:0] dvs;      // |divisor|
  logic [DIV_WIDTH-1:0] rem;      // partial remainder
  logic [DIV_WIDTH-1:0] q;        // dividend shifts out of the top, quotient bits shift in at the bottom
  logic [CNT_W-1:0]     cnt;
  logic                 neg_q;
  logic                 neg_r;

  logic [DIV_WIDTH:0]   trial;
  logic [DIV_WIDTH-1:0] mag1;
  logic [DIV_WIDTH-1:0] mag2;

  always_comb begin
    trial = {rem, q[DIV_WIDTH-1]} - {1'b0, dvs};
    mag1  = (sgn && op1[DIV_WIDTH-1]) ? -op1 : op1;
    mag2  = (sgn && op2[DIV_WIDTH-1]) ? -op2 : op2;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      op1           <= '0;
      op2           <= '0;
      sgn           <= 1'b0;
      dvs           <= '0;
      rem           <= '0;
      q             <= '0;
      cnt           <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      A_div_busy    <= 1'b0;
      A_div_done    <= 1'b0;
      A_div_quot    <= '0;
      A_div_rem     <= '0;
      A_div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          A_div_done <= 1'b0;
          if (A_div_start) begin
            op1        <= A_div_src1;
            op2        <= A_div_src2;
            sgn        <= A_div_signed & SIGNED_EN;
            state      <= S_PREP;
            A_div_busy <= 1'b1;
          end else begin
            state      <= S_IDLE;
            A_div_busy <= 1'b0;
          end
        end

        S_PREP: begin
          neg_q <= sgn & (op1[DIV_WIDTH-1] ^ op2[DIV_WIDTH-1]);
          neg_r <= sgn & op1[DIV_WIDTH-1];
          rem   <= '0;
          q     <= mag1;
          dvs   <= mag2;
          cnt   <= CNT_LAST;
          if (op2 == '0) begin
            A_div_quot    <= '1;
            A_div_rem     <= op1;
            A_div_by_zero <= 1'b1;
            A_div_busy    <= 1'b0;
            A_div_done    <= 1'b1;
            state         <= S_DONE;
          end else begin
            state <= S_ITER;
          end
        end

        S_ITER: begin
          // trial[DIV_WIDTH] is the borrow: set means the divisor did not fit
          if (!trial[DIV_WIDTH]) begin
            rem <= trial[DIV_WIDTH-1:0];
          end else begin
            rem <= {rem[DIV_WIDTH-2:0], q[DIV_WIDTH-1]};
          end
          q <= {q[DIV_WIDTH-2:0], ~trial[DIV_WIDTH]};
          if (cnt == CNT_ZERO) begin
            state <= S_FIX;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        S_FIX: begin
          // neg_q/neg_r are constant 0 when signed support is compiled out
          A_div_quot    <= neg_q ? -q : q;
          A_div_rem     <= neg_r ? -rem : rem;
          A_div_by_zero <= 1'b0;
          A_div_busy    <= 1'b0;
          A_div_done    <= 1'b1;
          state         <= S_DONE;
        end

        default: begin
          state      <= S_IDLE;
          A_div_busy <= 1'b0;
          A_div_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reloj_nios2_qsys_0_div_cell.sv
// tb/tb_reloj_nios2_qsys_0_div_cell.sv - scoreboard bench for the divider cell

module tb_reloj_nios2_qsys_0_div_cell;

`ifdef RELOJ_DIV_SIGNED_EN
  localparam bit SEN = 1'b1;
`else
  localparam bit SEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        A_div_start = 1'b0;
  logic [31:0] A_div_src1 = '0;
  logic [31:0] A_div_src2 = '0;
  logic        A_div_signed = 1'b0;
  logic        A_div_busy;
  logic        A_div_done;
  logic [31:0] A_div_quot;
  logic [31:0] A_div_rem;
  logic        A_div_by_zero;

  reloj_nios2_qsys_0_div_cell #(.DIV_WIDTH(32)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .A_div_start   (A_div_start),
    .A_div_src1    (A_div_src1),
    .A_div_src2    (A_div_src2),
    .A_div_signed  (A_div_signed),
    .A_div_busy    (A_div_busy),
    .A_div_done    (A_div_done),
    .A_div_quot    (A_div_quot),
    .A_div_rem     (A_div_rem),
    .A_div_by_zero (A_div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          dc;
    logic [31:0] q;
    logic [31:0] r;
    logic        bz;
  } exp_t;

  exp_t sb[$];

  int n_chk = 0;
  int n_fail = 0;

  int next_ready = 0;
  int busy_from = 0;
  int busy_to = 0;
  bit mon_en = 1'b0;
  bit hold_valid = 1'b0;
  logic [31:0] held_q = '0;
  logic [31:0] held_r = '0;
  logic held_bz = 1'b0;
  logic exp_busy;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic s, input int dc);
    exp_t e;
    int sa;
    int sb_;
    e.dc = dc;
    e.bz = 1'b0;
    if (b == 32'd0) begin
      e.q  = 32'hFFFF_FFFF;
      e.r  = a;
      e.bz = 1'b1;
    end else if (s && SEN) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.q = 32'h8000_0000;
        e.r = 32'd0;
      end else begin
        sa  = a;
        sb_ = b;
        e.q = sa / sb_;
        e.r = sa % sb_;
      end
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Scoreboard monitor: sampled on the falling edge
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      exp_busy = (cyc >= busy_from) && (cyc < busy_to);
      n_chk++;
      if (A_div_busy !== exp_busy) begin
        n_fail++;
        $display("FAIL busy cycle %0d: got %b want %b", cyc, A_div_busy, exp_busy);
      end
      if (sb.size() > 0 && cyc == sb[0].dc) begin
        e = sb.pop_front();
        n_chk++;
        if (A_div_done !== 1'b1) begin
          n_fail++;
          $display("FAIL done_missing cycle %0d: got %b want 1", cyc, A_div_done);
        end
        n_chk++;
        if (A_div_quot !== e.q) begin
          n_fail++;
          $display("FAIL quot cycle %0d: got %h want %h", cyc, A_div_quot, e.q);
        end
        n_chk++;
        if (A_div_rem !== e.r) begin
          n_fail++;
          $display("FAIL rem cycle %0d: got %h want %h", cyc, A_div_rem, e.r);
        end
        n_chk++;
        if (A_div_by_zero !== e.bz) begin
          n_fail++;
          $display("FAIL by_zero cycle %0d: got %b want %b", cyc, A_div_by_zero, e.bz);
        end
        held_q = e.q;
        held_r = e.r;
        held_bz = e.bz;
      end else begin
        n_chk++;
        if (A_div_done !== 1'b0) begin
          n_fail++;
          $display("FAIL done_spurious cycle %0d: got %b want 0", cyc, A_div_done);
        end
      end
      if (hold_valid) begin
        n_chk++;
        if (A_div_quot !== held_q || A_div_rem !== held_r || A_div_by_zero !== held_bz) begin
          n_fail++;
          $display("FAIL hold cycle %0d: got %h/%h/%b want %h/%h/%b", cyc,
                   A_div_quot, A_div_rem, A_div_by_zero, held_q, held_r, held_bz);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a start for one cycle; the model decides whether the cell accepts it
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    int dc;
    A_div_start  = 1'b1;
    A_div_src1   = a;
    A_div_src2   = b;
    A_div_signed = s;
    if (cyc >= next_ready) begin
      dc = cyc + ((b == 32'd0) ? 2 : 35);
      sb.push_back(model(a, b, s, dc));
      busy_from  = cyc + 1;
      busy_to    = dc;
      next_ready = dc;
    end
    tick();
    A_div_start  = 1'b0;
    A_div_src1   = $urandom;
    A_div_src2   = $urandom;
    A_div_signed = $urandom_range(0, 1);
  endtask

  task automatic wait_ready();
    int budget = 100;
    while (cyc < next_ready && budget > 0) begin
      tick();
      budget--;
    end
    if (cyc < next_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_ready: cycle %0d still before %0d", cyc, next_ready);
    end
  endtask

  task automatic check_zero(input string name);
    n_chk++;
    if (A_div_quot !== 32'd0 || A_div_rem !== 32'd0 || A_div_by_zero !== 1'b0 ||
        A_div_busy !== 1'b0 || A_div_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got q=%h r=%h bz=%b busy=%b done=%b want all 0", name,
               A_div_quot, A_div_rem, A_div_by_zero, A_div_busy, A_div_done);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int c0;

    reset_n = 1'b0;
    repeat (3) tick();
    check_zero("reset_state");
    reset_n = 1'b1;
    tick();
    check_zero("after_release");
    held_q = '0; held_r = '0; held_bz = 1'b0;
    hold_valid = 1'b1;
    busy_to = 0;
    next_ready = 0;
    mon_en = 1'b1;

    // Directed cases
    issue(32'd100, 32'd7, 1'b0);            wait_ready();
    issue(-32'sd100, 32'd7, 1'b1);          wait_ready();
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_ready();
    issue(32'h1234_5678, 32'd0, 1'b0);      wait_ready();
    issue(32'd9, 32'd3, 1'b0);              wait_ready();
    issue(32'h8000_0001, 32'd0, 1'b1);      wait_ready();
    issue(32'd7, -32'sd2, 1'b1);            wait_ready();

    // Start while busy: second start at cycle 10 must be ignored
    c0 = cyc;
    issue(32'd50, 32'd5, 1'b0);
    while (cyc < c0 + 10) tick();
    issue(32'd1, 32'd1, 1'b0);
    wait_ready();

    // Back-to-back: start in the DONE cycle of the previous operation
    issue(32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_ready();
    issue(32'd7, 32'd2, 1'b0);
    wait_ready();

    // Reset mid-operation
    c0 = cyc;
    issue(32'd1000, 32'd3, 1'b0);
    while (cyc < c0 + 20) tick();
    reset_n = 1'b0;
    hold_valid = 1'b0;
    sb.delete();
    busy_to = cyc + 1;
    next_ready = 0;
    tick();
    check_zero("mid_reset");
    reset_n = 1'b1;
    held_q = '0; held_r = '0; held_bz = 1'b0;
    hold_valid = 1'b1;
    tick();
    issue(32'd1000, 32'd3, 1'b0);
    wait_ready();

    // Randomized operations, with gaps, back-to-back starts and ignored starts
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = -($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 5) == 0) b = 32'hFFFF_FFFF;
      repeat ($urandom_range(0, 3)) tick();
      issue(a, b, $urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 5)) tick();
        issue($urandom, $urandom_range(1, 9), 1'b0);
      end
      wait_ready();
    end

    repeat (3) tick();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
